// File: rtl/i2c_master_control.sv
// I2C master sequencer: start, address/data bytes, slave ACK, master ACK/NACK, stop.
// Define I2C_ACK_ABORT_EN to end the transfer with a stop after any slave NACK.
module i2c_master_control #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   Reset,
  input  logic                   ClockI2C,
  input  logic                   Go,
  input  logic [COUNT_WIDTH-1:0] NumBytes,
  input  logic                   ReadMode,
  input  logic                   SDAIn,
  output logic                   BaudEnable,
  output logic                   ReadorWrite,
  output logic                   Select,
  output logic                   ShiftorHold,
  output logic                   StartStopAck,
  output logic                   WriteLoad,
  output logic                   Busy,
  output logic                   Done,
  output logic                   AckError
);

  localparam int BIT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_WIDTH-1:0] LAST_BIT = BIT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] FULL_BYTE = BIT_WIDTH'(DATA_WIDTH);

  typedef enum logic [3:0] {
    Initial, Start, Load, Write, Acknowledge, Read, MasterAck, Transit, Stop
  } stateT;

  stateT                  state, nextState;
  logic                   clockI2CPrev;
  logic                   rise, fall;
  logic [BIT_WIDTH-1:0]   bitCount;
  logic [COUNT_WIDTH-1:0] byteCount;
  logic                   readModeReg;
  logic                   addressPhase;
  logic                   bytesRemain;
  logic                   ackAbort;

  assign rise        = ClockI2C & ~clockI2CPrev;
  assign fall        = ~ClockI2C & clockI2CPrev;
  // byteCount includes the byte in flight, so "more to come" means above one.
  assign bytesRemain = byteCount > COUNT_WIDTH'(1);

`ifdef I2C_ACK_ABORT_EN
  assign ackAbort = AckError;
`else
  assign ackAbort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (Reset) state <= Initial;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      Initial:     if (Go) nextState = Start;
      Start:       if (fall) nextState = Load;
      Load:        nextState = Write;
      Write:       if (fall && bitCount == LAST_BIT) nextState = Acknowledge;
      Acknowledge: if (fall) begin
        if (ackAbort)          nextState = Transit;
        else if (addressPhase) nextState = (byteCount == '0) ? Transit : (readModeReg ? Read : Load);
        else                   nextState = bytesRemain ? Load : Transit;
      end
      Read:        if (fall && bitCount == FULL_BYTE) nextState = MasterAck;
      MasterAck:   if (fall) nextState = bytesRemain ? Read : Transit;
      Transit:     if (rise) nextState = Stop;
      Stop:        nextState = Initial;
      default:     nextState = Initial;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      clockI2CPrev <= 1'b1;
      bitCount     <= '0;
      byteCount    <= '0;
      readModeReg  <= 1'b0;
      addressPhase <= 1'b0;
      AckError     <= 1'b0;
    end else begin
      clockI2CPrev <= ClockI2C;

      if (state == Initial && Go) begin
        byteCount    <= NumBytes;
        readModeReg  <= ReadMode;
        addressPhase <= 1'b1;
        AckError     <= 1'b0;
      end

      // Counting bits only inside Write/Read makes every entry start from zero.
      if ((state == Write && fall) || (state == Read && rise && bitCount != FULL_BYTE))
        bitCount <= bitCount + BIT_WIDTH'(1);
      else if (state != Write && state != Read)
        bitCount <= '0;

      if (state == Acknowledge && rise && SDAIn) AckError <= 1'b1;

      if (state == Acknowledge && fall) begin
        if (!addressPhase) byteCount <= byteCount - COUNT_WIDTH'(1);
        addressPhase <= 1'b0;
      end

      if (state == MasterAck && fall) byteCount <= byteCount - COUNT_WIDTH'(1);
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    BaudEnable   = 1'b1;
    ReadorWrite  = 1'b0;
    Select       = 1'b0;
    StartStopAck = 1'b1;
    ShiftorHold  = 1'b0;
    WriteLoad    = 1'b0;
    Busy         = 1'b1;
    Done         = 1'b0;
    unique case (state)
      Initial: begin
        BaudEnable = 1'b0;
        Busy       = 1'b0;
      end
      Start:       StartStopAck = 1'b0;
      Load:        WriteLoad = 1'b1;
      Write: begin
        Select      = 1'b1;
        ShiftorHold = fall;
      end
      Acknowledge: ReadorWrite = 1'b1;
      Read: begin
        ReadorWrite = 1'b1;
        ShiftorHold = rise && (bitCount != FULL_BYTE);
      end
      MasterAck:   StartStopAck = ~bytesRemain;
      Transit:     StartStopAck = 1'b0;
      Stop: begin
        Done       = 1'b1;
        BaudEnable = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_control.sv
// Directed bench for i2c_master_control: counts strobes per transfer and checks
// them against hand-derived totals; honours I2C_ACK_ABORT_EN for NACK expectations.
module tb_i2c_master_control;

  logic       clock = 1'b0;
  logic       Reset;
  logic       ClockI2C;
  logic       Go;
  logic [2:0] NumBytes;
  logic       ReadMode;
  logic       SDAIn;
  logic       BaudEnable, ReadorWrite, Select, ShiftorHold, StartStopAck;
  logic       WriteLoad, Busy, Done, AckError;

  int compareCount  = 0;
  int mismatchCount = 0;

  int         loadCount, writeShifts, readShifts, doneCount, masterAckCount;
  logic [7:0] masterAckLevels;
  logic       prevRow = 1'b0;
  int         sclDiv = 0;

  i2c_master_control #(.DATA_WIDTH(8), .COUNT_WIDTH(3)) dut (
    .clock(clock), .Reset(Reset), .ClockI2C(ClockI2C), .Go(Go),
    .NumBytes(NumBytes), .ReadMode(ReadMode), .SDAIn(SDAIn),
    .BaudEnable(BaudEnable), .ReadorWrite(ReadorWrite), .Select(Select),
    .ShiftorHold(ShiftorHold), .StartStopAck(StartStopAck), .WriteLoad(WriteLoad),
    .Busy(Busy), .Done(Done), .AckError(AckError)
  );

  always #5 clock = ~clock;

  // SCL generator: idles high, toggles every 4 system clocks while enabled.
  initial begin
    ClockI2C = 1'b1;
    forever begin
      @(negedge clock);
      if (!BaudEnable) begin
        ClockI2C = 1'b1;
        sclDiv   = 0;
      end else if (sclDiv == 3) begin
        ClockI2C = ~ClockI2C;
        sclDiv   = 0;
      end else begin
        sclDiv++;
      end
    end
  end

  // Strobe monitor; a 1->0 on ReadorWrite in a read transfer marks MasterAck entry.
  always @(negedge clock) begin
    if (WriteLoad) loadCount++;
    if (ShiftorHold && !ReadorWrite) writeShifts++;
    if (ShiftorHold && ReadorWrite) readShifts++;
    if (Done) doneCount++;
    if (prevRow && !ReadorWrite) begin
      masterAckLevels = {masterAckLevels[6:0], StartStopAck};
      masterAckCount++;
    end
    prevRow = ReadorWrite;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_baud"},  BaudEnable,   1'b0);
    check({tag, "_row"},   ReadorWrite,  1'b0);
    check({tag, "_sel"},   Select,       1'b0);
    check({tag, "_ssa"},   StartStopAck, 1'b1);
    check({tag, "_shift"}, ShiftorHold,  1'b0);
    check({tag, "_load"},  WriteLoad,    1'b0);
    check({tag, "_busy"},  Busy,         1'b0);
    check({tag, "_done"},  Done,         1'b0);
    check({tag, "_ackerr"}, AckError,    1'b0);
  endtask

  task automatic startGo(input logic [2:0] n, input logic rm);
    @(negedge clock);
    loadCount = 0; writeShifts = 0; readShifts = 0; doneCount = 0;
    masterAckCount = 0; masterAckLevels = '0;
    NumBytes = n;
    ReadMode = rm;
    Go = 1'b1;
    @(negedge clock);
    Go = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clock);
      if (Done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    repeat (3) @(negedge clock);
    check({tag, "_done_pulses"}, doneCount, 1);
    check({tag, "_idle_busy"}, Busy, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Go = 1'b0; NumBytes = '0; ReadMode = 1'b0; SDAIn = 1'b0;
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);
    checkIdle("reset");

    // Write, two data bytes, all ACKed
    startGo(3'd2, 1'b0);
    waitDone("wr2");
    check("wr2_loads", loadCount, 3);
    check("wr2_wshifts", writeShifts, 24);
    check("wr2_rshifts", readShifts, 0);
    check("wr2_ackerr", AckError, 1'b0);

    // Read, three data bytes: ACK, ACK, NACK from the master
    startGo(3'd3, 1'b1);
    waitDone("rd3");
    check("rd3_loads", loadCount, 1);
    check("rd3_wshifts", writeShifts, 8);
    check("rd3_rshifts", readShifts, 24);
    check("rd3_mack_count", masterAckCount, 3);
    check("rd3_mack_levels", masterAckLevels[2:0], 3'b001);
    check("rd3_ackerr", AckError, 1'b0);

    // Address-only transfer
    startGo(3'd0, 1'b0);
    waitDone("addr");
    check("addr_loads", loadCount, 1);
    check("addr_wshifts", writeShifts, 8);
    check("addr_rshifts", readShifts, 0);

    // Slave NACKs every frame
    SDAIn = 1'b1;
    startGo(3'd2, 1'b0);
    waitDone("nack");
    SDAIn = 1'b0;
    check("nack_ackerr", AckError, 1'b1);
`ifdef I2C_ACK_ABORT_EN
    check("nack_loads", loadCount, 1);
    check("nack_wshifts", writeShifts, 8);
`else
    check("nack_loads", loadCount, 3);
    check("nack_wshifts", writeShifts, 24);
`endif

    // Clean transfer clears the sticky error
    startGo(3'd1, 1'b0);
    waitDone("wr1");
    check("wr1_ackerr", AckError, 1'b0);
    check("wr1_loads", loadCount, 2);
    check("wr1_wshifts", writeShifts, 16);

    // Reset in the middle of the address byte
    startGo(3'd1, 1'b0);
    for (int i = 0; i < 2000 && writeShifts < 4; i++) @(negedge clock);
    check("mid_bit4", writeShifts, 4);
    check("mid_busy", Busy, 1'b1);
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b0;
    checkIdle("midrst");
    repeat (5) @(negedge clock);
    startGo(3'd1, 1'b0);
    waitDone("restart");
    check("restart_loads", loadCount, 2);
    check("restart_wshifts", writeShifts, 16);

    // Go while busy is ignored
    startGo(3'd1, 1'b0);
    repeat (40) @(negedge clock);
    NumBytes = 3'd5; ReadMode = 1'b1; Go = 1'b1;
    @(negedge clock);
    Go = 1'b0;
    check("gobusy_busy", Busy, 1'b1);
    waitDone("gobusy");
    check("gobusy_loads", loadCount, 2);
    check("gobusy_wshifts", writeShifts, 16);
    check("gobusy_rshifts", readShifts, 0);

    // Go and Reset together while busy: reset wins, Go not latched
    startGo(3'd2, 1'b0);
    repeat (30) @(negedge clock);
    Go = 1'b1; Reset = 1'b1;
    @(negedge clock);
    Go = 1'b0; Reset = 1'b0;
    check("gorst_busy", Busy, 1'b0);
    check("gorst_baud", BaudEnable, 1'b0);
    check("gorst_ssa", StartStopAck, 1'b1);
    repeat (5) @(negedge clock);
    check("gorst_stay_idle", Busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/i2c_master_control.md
I2C_MASTER_CONTROL -- requirements
Module: i2c_master_control

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per I2C byte frame.
REQ-002 Parameter COUNT_WIDTH, default 3: width of NumBytes; data-byte count range 0..2^COUNT_WIDTH-1.
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 ClockI2C  in  1  SCL level from the baud generator, sampled on clock.
REQ-006 Go  in  1  start request, sampled only in Initial.
REQ-007 NumBytes  in  COUNT_WIDTH  data bytes after the address frame, latched on Go.
REQ-008 ReadMode  in  1  0 = write transfer, 1 = read transfer, latched on Go.
REQ-009 SDAIn  in  1  sampled SDA, used for slave ACK.
REQ-010 BaudEnable  out  1  enables the SCL generator.
REQ-011 ReadorWrite  out  1  1 = master releases SDA, 0 = master drives SDA.
REQ-012 Select  out  1  SDA source: 1 = shift register MSB, 0 = StartStopAck.
REQ-013 ShiftorHold  out  1  one-cycle shift strobe for the shift register.
REQ-014 StartStopAck  out  1  SDA level when Select=0.
REQ-015 WriteLoad  out  1  one-cycle parallel-load strobe for the shift register.
REQ-016 Busy  out  1; Done  out  1 (one-cycle pulse); AckError  out  1 (sticky).

Function
REQ-017 Edges SHALL be detected against a registered copy of ClockI2C: rise = 0->1, fall = 1->0, one clock after the change.
REQ-018 States SHALL be Initial, Start, Load, Write, Acknowledge, Read, MasterAck, Transit and Stop.
REQ-019 Initial: BaudEnable=0, Select=0, StartStopAck=1, Busy=0; Go=1 -> Start; latch NumBytes and ReadMode; clear AckError.
REQ-020 Start: BaudEnable=1, Select=0, StartStopAck=0; fall -> Load.
REQ-021 Load: WriteLoad=1 for exactly one clock, then Write; the first load is the address frame, later loads are data.
REQ-022 Write: Select=1, ReadorWrite=0; ShiftorHold=1 for one clock per fall; after the DATA_WIDTH-th fall -> Acknowledge.
REQ-023 Acknowledge: ReadorWrite=1; sample SDAIn on rise and set AckError if it is 1; on fall -> Load (write, bytes remaining), Read (read, after address), or Transit (no bytes remaining).
REQ-024 Read: ReadorWrite=1; ShiftorHold=1 for one clock per rise; after the DATA_WIDTH-th rise, the next fall -> MasterAck.
REQ-025 MasterAck: ReadorWrite=0, Select=0; StartStopAck=0 if bytes remain, else 1 (NACK); fall -> Read or Transit.
REQ-026 Transit: Select=0, StartStopAck=0; rise -> Stop.
REQ-027 Stop: StartStopAck=1 (stop condition); after one clock, Done=1 for one clock, BaudEnable=0 -> Initial.
REQ-028 The byte counter SHALL decrement after each data-byte ACK or MasterAck; NumBytes=0 SHALL give an address-only transfer (Acknowledge -> Transit).
REQ-029 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits wide and clear on entering Write or Read.
REQ-030 Go SHALL be ignored while Busy=1; Busy SHALL be 1 in every state except Initial.

Reset
REQ-031 Reset=1 SHALL force Initial on the next edge from any state and override a simultaneous Go.
REQ-032 Reset values: BaudEnable=0, ReadorWrite=0, Select=0, StartStopAck=1, ShiftorHold=0, WriteLoad=0, Busy=0, Done=0, AckError=0, counters=0.

Configuration
REQ-033 With I2C_ACK_ABORT_EN defined, AckError=1 in Acknowledge SHALL route the fall to Transit, then Stop.
REQ-034 Without I2C_ACK_ABORT_EN, AckError SHALL still be flagged, but the transfer SHALL continue per REQ-023.

Verification
REQ-035 Write with NumBytes=2, ACK=0 throughout -> 3 WriteLoad pulses, 24 ShiftorHold pulses, Done pulse, AckError=0.
REQ-036 Read with NumBytes=3 -> 8 write shifts, then 24 read shifts; MasterAck StartStopAck = 0, 0, 1; then Done.
REQ-037 NumBytes=0, Go -> 1 WriteLoad, Acknowledge -> Transit -> Stop, Done after the address ACK.
REQ-038 SDAIn=1 at address ACK: with I2C_ACK_ABORT_EN -> Stop, AckError=1, 1 WriteLoad total; without it -> full transfer, AckError=1.
REQ-039 Reset asserted mid-Write at bit 4 -> Initial next clock with all REQ-032 values; a later Go restarts cleanly.
REQ-040 Go pulsed while Busy -> no state disturbance; Go and Reset in the same cycle -> Initial.
